// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding and frame constants.
// Used by both the receiver and the transmitter.
package uart_pkg;

    localparam int unsigned DATA_BITS = 8;
    localparam logic        LINE_IDLE = 1'b1;

    typedef enum logic [2:0] {
        StIdle,
        StStart,
        StData,
        StStop,
        StCleanup,
        StWaitHigh
    } uart_state_e;

endpackage

// File: rtl/uart_bit_sync.sv
// Two-flop synchronizer for a single asynchronous input.
// Both flops reset to ResetVal so an idle line is not mistaken for activity.
module uart_bit_sync
    import uart_pkg::*;
#(
    parameter logic ResetVal = LINE_IDLE
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_async,
    output logic o_sync
);

    logic [1:0] sync_q;

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            sync_q <= {2{ResetVal}};
        end else begin
            sync_q <= {sync_q[0], i_async};
        end
    end

    assign o_sync = sync_q[1];

endmodule

// File: rtl/uart_rxr.sv
// UART 8N1 receiver: start-bit glitch rejection, mid-bit sampling,
// one-cycle data-valid and framing-error strobes.
module uart_rxr
    import uart_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = 10
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    input  logic                 i_dataline,
    output logic [DATA_BITS-1:0] o_byte,
    output logic                 o_data_valid,
    output logic                 o_framing_error,
    output logic                 o_busy
);

    localparam int unsigned CntW = $clog2(CLKS_PER_BIT);
    // START is entered one cycle after t0, so HALF-1 in the counter lands on t0+HALF.
    localparam logic [CntW-1:0] HalfM1  = CntW'((CLKS_PER_BIT - 1) / 2 - 1);
    localparam logic [CntW-1:0] BitLast = CntW'(CLKS_PER_BIT - 1);
    localparam logic [2:0]      IdxLast = 3'(DATA_BITS - 1);

    uart_state_e          state_q, state_d;
    logic [CntW-1:0]      clk_cnt_q, clk_cnt_d;
    logic [2:0]           bit_idx_q, bit_idx_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic [DATA_BITS-1:0] byte_q, byte_d;
    logic                 valid_q, valid_d;
    logic                 ferr_q, ferr_d;
    logic                 busy_q, busy_d;
    logic                 rx_s;

    uart_bit_sync #(
        .ResetVal(LINE_IDLE)
    ) u_sync (
        .i_clk  (i_clk),
        .i_rst_n(i_rst_n),
        .i_async(i_dataline),
        .o_sync (rx_s)
    );

    always_comb begin
        state_d   = state_q;
        clk_cnt_d = clk_cnt_q;
        bit_idx_d = bit_idx_q;
        shift_d   = shift_q;
        byte_d    = byte_q;
        valid_d   = 1'b0;
        ferr_d    = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (rx_s != LINE_IDLE) begin
                    state_d   = StStart;
                    clk_cnt_d = '0;
                end
            end
            StStart: begin
                if (clk_cnt_q == HalfM1) begin
                    if (rx_s == LINE_IDLE) begin
                        state_d = StIdle;
                    end else begin
                        state_d   = StData;
                        clk_cnt_d = '0;
                        bit_idx_d = '0;
                    end
                end else begin
                    clk_cnt_d = clk_cnt_q + CntW'(1);
                end
            end
            StData: begin
                if (clk_cnt_q == BitLast) begin
                    clk_cnt_d          = '0;
                    shift_d[bit_idx_q] = rx_s;
                    bit_idx_d          = bit_idx_q + 3'd1;
                    if (bit_idx_q == IdxLast) begin
                        state_d = StStop;
                    end
                end else begin
                    clk_cnt_d = clk_cnt_q + CntW'(1);
                end
            end
            StStop: begin
                if (clk_cnt_q == BitLast) begin
                    clk_cnt_d = '0;
                    if (rx_s == LINE_IDLE) begin
                        byte_d  = shift_q;
                        valid_d = 1'b1;
                        state_d = StCleanup;
                    end else begin
                        ferr_d  = 1'b1;
                        state_d = StWaitHigh;
                    end
                end else begin
                    clk_cnt_d = clk_cnt_q + CntW'(1);
                end
            end
            StCleanup: begin
                state_d = StIdle;
            end
            StWaitHigh: begin
                // A held-low line or break stays here so only one error pulse is raised.
                if (rx_s == LINE_IDLE) begin
                    state_d = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
        busy_d = (state_d != StIdle);
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state_q   <= StIdle;
            clk_cnt_q <= '0;
            bit_idx_q <= '0;
            shift_q   <= '0;
            byte_q    <= '0;
            valid_q   <= 1'b0;
            ferr_q    <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            clk_cnt_q <= clk_cnt_d;
            bit_idx_q <= bit_idx_d;
            shift_q   <= shift_d;
            byte_q    <= byte_d;
            valid_q   <= valid_d;
            ferr_q    <= ferr_d;
            busy_q    <= busy_d;
        end
    end

    assign o_byte          = byte_q;
    assign o_data_valid    = valid_q;
    assign o_framing_error = ferr_q;
    assign o_busy          = busy_q;

endmodule
